viterbi_frame_collector: RTL and testbench



---
 rtl/viterbi_frame_collector.sv | 183 ++++++++++++++++++
 tb/tb_viterbi_frame_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_collector.sv
// -----------------------------------------------------------------------------
// viterbi_frame_collector
//
// Collects the decoded symbol pairs leaving the Viterbi core into one frame of
// NUM_CH 3-bit two's-complement symbols, then publishes the frame on a
// valid/ready output register. The collection buffer and the output register
// are separate, so a new frame can be collected while the consumer still holds
// off the previous one.
//
// Optional build macro:
//   VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN  - flag writes to positions already
//                                           written in the current frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sym_in            B_LEN symbols; element k targets (sym_pos+k) mod NUM_CH
//   sym_run           sym_in valid this cycle
//   sym_init          discard the partial frame (wins over sym_run)
//   sym_frame_end     last write of a frame (qualified by sym_run)
//   sym_pos           base position of sym_in
//   frame_out         published frame, element i = position i
//   frame_mask        bit i set if position i was written in that frame
//   frame_incomplete  frame_mask not all ones
//   out_valid         published frame valid; held until out_ready
//   out_ready         consumer accepts on out_valid & out_ready
//   frame_count       frames published (wraps)
//   overrun           sticky: a completed frame was dropped under backpressure
//   dup_err           sticky duplicate-write flag (0 unless macro defined)
// -----------------------------------------------------------------------------
module viterbi_frame_collector #(
  parameter int NUM_CH = 40,
  parameter int B_LEN  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [B_LEN-1:0][2:0]          sym_in,
  input  logic                           sym_run,
  input  logic                           sym_init,
  input  logic                           sym_frame_end,
  input  logic [$clog2(NUM_CH)-1:0]      sym_pos,
  output logic [NUM_CH-1:0][2:0]         frame_out,
  output logic [NUM_CH-1:0]              frame_mask,
  output logic                           frame_incomplete,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               frame_count,
  output logic                           overrun,
  output logic                           dup_err
);

  localparam int POS_W = $clog2(NUM_CH);

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0][2:0]  buf_q;
  logic [NUM_CH-1:0]       mask_q;
  logic [NUM_CH-1:0][2:0]  merged_buf;
  logic [NUM_CH-1:0]       merged_mask;
  logic [POS_W:0]          wr_idx;
  logic                    write_en;
  logic                    complete;
  logic                    load_out;
  logic                    drop;

  // sym_init discards any write arriving in the same cycle.
  assign write_en = sym_run & ~sym_init;
  assign complete = write_en & sym_frame_end;
  // A completing frame loads if the output slot is free or is being freed now.
  assign load_out = complete & (~out_valid | out_ready);
  assign drop     = complete & out_valid & ~out_ready;

`ifdef VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN
  logic dup_hit;
`endif

  // Buffer merged with this cycle's writes; used both to update the buffer and
  // to publish a frame in its completion cycle.
  // NOTE: blocking assignments here are deliberate: later symbols in the loop
  // must see (and overwrite) earlier ones so the last write wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    merged_buf  = buf_q;
    merged_mask = mask_q;
    wr_idx      = '0;
`ifdef VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN
    dup_hit     = 1'b0;
`endif
    if (write_en) begin
      for (int k = 0; k < B_LEN; k++) begin
        // Modulo wrap without a divider: sym_pos < NUM_CH and k < NUM_CH.
        wr_idx = (POS_W+1)'(sym_pos) + (POS_W+1)'(k);
        if (wr_idx >= (POS_W+1)'(NUM_CH)) begin
          wr_idx = wr_idx - (POS_W+1)'(NUM_CH);
        end
`ifdef VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN
        if (merged_mask[wr_idx[POS_W-1:0]]) begin
          dup_hit = 1'b1;
        end
`endif
        merged_buf[wr_idx[POS_W-1:0]]  = sym_in[k];
        merged_mask[wr_idx[POS_W-1:0]] = 1'b1;
      end
    end
  end

  // Collect FSM: tracks whether a partial frame is in progress.
  always_comb begin
    state_d = state_q;
    if (sym_init) begin
      state_d = ST_IDLE;
    end else if (sym_run) begin
      state_d = sym_frame_end ? ST_IDLE : ST_COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Collection buffer.
  // NOTE: this array is register-based and must start empty after reset so the
  // first frame's mask is exact; it is therefore reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      mask_q <= '0;
    end else if (sym_init || complete) begin
      buf_q  <= '0;
      mask_q <= '0;
    end else if (write_en) begin
      buf_q  <= merged_buf;
      mask_q <= merged_mask;
    end
  end

  // Output register and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_out        <= '0;
      frame_mask       <= '0;
      frame_incomplete <= 1'b0;
      out_valid        <= 1'b0;
      frame_count      <= '0;
      overrun          <= 1'b0;
    end else begin
      if (load_out) begin
        frame_out        <= merged_buf;
        frame_mask       <= merged_mask;
        frame_incomplete <= ~&merged_mask;
        out_valid        <= 1'b1;
        frame_count      <= frame_count + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
    end else if (dup_hit) begin
      dup_err <= 1'b1;
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_viterbi_frame_collector
//
// Directed bench for viterbi_frame_collector. Expected frames are pushed into a
// scoreboard queue when stimulus is issued; a monitor pops and compares them
// whenever the DUT hands a frame over (out_valid & out_ready). Status outputs
// are checked directly at fixed points of the sequence.
// -----------------------------------------------------------------------------
module tb_viterbi_frame_collector;

  localparam int NUM_CH = 40;
  localparam int B_LEN  = 2;
  localparam int CNT_W  = 16;
  localparam int POS_W  = $clog2(NUM_CH);

`ifdef VITERBI_FRAME_COLLECTOR_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  typedef struct {
    logic [NUM_CH-1:0][2:0] data;
    logic [NUM_CH-1:0]      mask;
    logic                   inc;
    logic [CNT_W-1:0]       cnt;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [B_LEN-1:0][2:0]  sym_in;
  logic                   sym_run;
  logic                   sym_init;
  logic                   sym_frame_end;
  logic [POS_W-1:0]       sym_pos;
  logic [NUM_CH-1:0][2:0] frame_out;
  logic [NUM_CH-1:0]      frame_mask;
  logic                   frame_incomplete;
  logic                   out_valid;
  logic                   out_ready;
  logic [CNT_W-1:0]       frame_count;
  logic                   overrun;
  logic                   dup_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  viterbi_frame_collector #(
    .NUM_CH(NUM_CH),
    .B_LEN (B_LEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sym_in          (sym_in),
    .sym_run         (sym_run),
    .sym_init        (sym_init),
    .sym_frame_end   (sym_frame_end),
    .sym_pos         (sym_pos),
    .frame_out       (frame_out),
    .frame_mask      (frame_mask),
    .frame_incomplete(frame_incomplete),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .frame_count     (frame_count),
    .overrun         (overrun),
    .dup_err         (dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of input; returns 1 time unit after the sampling edge.
  task automatic step(input bit run, input bit init, input bit fe,
                      input int pos, input int s0, input int s1);
    sym_run       = run;
    sym_init      = init;
    sym_frame_end = fe;
    sym_pos       = POS_W'(pos);
    sym_in[0]     = 3'(s0);
    sym_in[1]     = 3'(s1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  function automatic exp_t empty_frame(input int cnt);
    exp_t e;
    e.data = '0;
    e.mask = '0;
    e.inc  = 1'b1;
    e.cnt  = CNT_W'(cnt);
    return e;
  endfunction

  // Full frame used by the directed tests: position p holds (p % 7) - 3.
  function automatic exp_t full_frame(input int cnt);
    exp_t e;
    for (int p = 0; p < NUM_CH; p++) begin
      e.data[p] = 3'((p % 7) - 3);
    end
    e.mask = '1;
    e.inc  = 1'b0;
    e.cnt  = CNT_W'(cnt);
    return e;
  endfunction

  task automatic send_full_frame();
    for (int i = 0; i < NUM_CH / B_LEN; i++) begin
      step(1'b1, 1'b0, (i == NUM_CH / B_LEN - 1), 2 * i,
           ((2 * i) % 7) - 3, ((2 * i + 1) % 7) - 3);
    end
  endtask

  // Scoreboard monitor: compares every frame handed to the consumer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_frame: got frame_count %0d with no frame expected", frame_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_out",        128'(frame_out),        128'(e.data));
        check("frame_mask",       128'(frame_mask),       128'(e.mask));
        check("frame_incomplete", 128'(frame_incomplete), 128'(e.inc));
        check("frame_count",      128'(frame_count),      128'(e.cnt));
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    out_ready = 1'b1;
    sym_run = 1'b0; sym_init = 1'b0; sym_frame_end = 1'b0;
    sym_pos = '0; sym_in = '0;

    // Reset state
    #3;
    check("rst_out_valid",   128'(out_valid),        128'(0));
    check("rst_frame_count", 128'(frame_count),      128'(0));
    check("rst_overrun",     128'(overrun),          128'(0));
    check("rst_frame_mask",  128'(frame_mask),       128'(0));
    check("rst_frame_out",   128'(frame_out),        128'(0));
    check("rst_incomplete",  128'(frame_incomplete), 128'(0));
    check("rst_dup_err",     128'(dup_err),          128'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame
    sb.push_back(full_frame(1));
    send_full_frame();
    check("full_out_valid",   128'(out_valid),   128'(1));
    check("full_frame_count", 128'(frame_count), 128'(1));
    idle();
    check("full_valid_drop",  128'(out_valid),   128'(0));

    // Wrap and partial: pos 39 writes positions 39 and 0
    e = empty_frame(2);
    e.data[39] = 3'(2);  e.mask[39] = 1'b1;
    e.data[0]  = 3'(-1); e.mask[0]  = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 39, 2, -1);
    check("wrap_out_valid", 128'(out_valid), 128'(1));
    idle();

    // Init mid-frame; init with simultaneous run+frame_end must not publish
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 2 * i, -4, -4);
    step(1'b1, 1'b1, 1'b1, 10, -4, -4);
    check("init_no_publish", 128'(out_valid),   128'(0));
    check("init_count_kept", 128'(frame_count), 128'(2));
    sb.push_back(full_frame(3));
    send_full_frame();
    check("init_full_count", 128'(frame_count), 128'(3));
    idle();

    // Init clears the buffer: a later partial frame shows only its own writes
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2 * i, 2, 2);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    e = empty_frame(4);
    e.data[20] = 3'(1);  e.mask[20] = 1'b1;
    e.data[21] = 3'(-2); e.mask[21] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 20, 1, -2);
    idle();

    // Accept and completion in the same cycle
    out_ready = 1'b0;
    e = empty_frame(5);
    e.data[12] = 3'(-3); e.mask[12] = 1'b1;
    e.data[13] = 3'(3);  e.mask[13] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 12, -3, 3);
    idle();
    check("hold_out_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    e = empty_frame(6);
    e.data[30] = 3'(1);  e.mask[30] = 1'b1;
    e.data[31] = 3'(-1); e.mask[31] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 30, 1, -1);
    check("acc_cmp_valid",   128'(out_valid),   128'(1));
    check("acc_cmp_overrun", 128'(overrun),     128'(0));
    check("acc_cmp_count",   128'(frame_count), 128'(6));
    idle();
    check("acc_cmp_drop", 128'(out_valid), 128'(0));

    // Backpressure: second completed frame is dropped
    out_ready = 1'b0;
    e = empty_frame(7);
    e.data[5] = 3'(1); e.mask[5] = 1'b1;
    e.data[6] = 3'(2); e.mask[6] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 5, 1, 2);
    step(1'b1, 1'b0, 1'b1, 7, 3, -2);
    check("bp_overrun",    128'(overrun),      128'(1));
    check("bp_count",      128'(frame_count),  128'(7));
    check("bp_out_valid",  128'(out_valid),    128'(1));
    check("bp_held_data",  128'(frame_out[5]), 128'(1));
    check("bp_held_mask",  128'(frame_mask),   128'(40'h60));
    idle();
    out_ready = 1'b1;
    idle();
    check("bp_accepted", 128'(out_valid), 128'(0));

    // Duplicate write to position 4: last value wins
    e = empty_frame(8);
    e.data[3] = 3'(2); e.mask[3] = 1'b1;
    e.data[4] = 3'(3); e.mask[4] = 1'b1;
    e.data[5] = 3'(1); e.mask[5] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b0, 4, 1, 1);
    step(1'b1, 1'b0, 1'b1, 3, 2, 3);
    check("dup_err", 128'(dup_err), 128'(DUP_EN));
    idle();

    // Asynchronous reset mid-frame with a pending output
    out_ready = 1'b0;
    step(1'b1, 1'b0, 1'b1, 0, 1, 1);
    step(1'b1, 1'b0, 1'b0, 10, 1, 1);
    sym_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid",   128'(out_valid),   128'(0));
    check("arst_frame_count", 128'(frame_count), 128'(0));
    check("arst_overrun",     128'(overrun),     128'(0));
    check("arst_dup_err",     128'(dup_err),     128'(0));
    check("arst_frame_mask",  128'(frame_mask),  128'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    e = empty_frame(1);
    e.data[38] = 3'(-1); e.mask[38] = 1'b1;
    e.data[39] = 3'(2);  e.mask[39] = 1'b1;
    sb.push_back(e);
    step(1'b1, 1'b0, 1'b1, 38, -1, 2);
    idle();
    idle();

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
